cp_if_pipe: RTL and testbench
=============================

CP_IF_PIPE -- requirements
Module: cp_if_pipe

Interface
REQ-001 Parameter PC_W, default 10, width of word-addressed PC and IMEM address.
REQ-002 Parameter INS_W, default 24, instruction width.
REQ-003 Parameter RF_IDX_W, default 5, register index width.
REQ-004 Parameter BP_SEL_W, default 2, bypass source select width; index is a bypass when its upper RF_IDX_W-BP_SEL_W bits are all ones.
REQ-005 Parameters SRC1_LSB (default 12), SRC2_LSB (default 7), TYPE_BIT (default 18): field positions within the instruction.
REQ-006 Parameter PRED_W, default 2, predication width.
REQ-007 Parameter BOOT_PC, default 0, reset fetch address.
REQ-008 Parameter DELAY_SLOT, default 1: 1 = instruction in flight at branch proceeds; 0 = it is squashed.
REQ-009 Parameter BRANCHOP_NOP, default 0, 3-bit branch-op reset and idle code.
REQ-010 iClk  in  1  system clock, rising edge.
REQ-011 iReset_n  in  1  asynchronous active-low reset.
REQ-012 iStall  in  1  ID-stage stall request.
REQ-013 iID_IF_Branch_Taken_Flag  in  1  redirect request; iID_IF_Branch_Target_Addr  in  PC_W  target.
REQ-014 iIMEM_IF_Instruction  in  INS_W  IMEM read data, one-cycle latency; oIF_IMEM_Addr  out  PC_W  IMEM address.
REQ-015 iSelect_First_PE, iSelect_Last_PE  in  1 each; iPredication  in  PRED_W: sideband captured with the instruction.
REQ-016 oIF_ID_Valid  out  1; oIF_ID_PC  out  PC_W; oIF_ID_Instruction  out  INS_W; oIF_ID_Branch_Op  out  3.
REQ-017 oSelect_First_PE, oSelect_Last_PE  out  1; oPredication  out  PRED_W.
REQ-018 oIF_RF_Read_Addr_A/B  out  RF_IDX_W; oIF_BP_Bypass_Read_A/B  out  1; oIF_BP_Bypass_Sel_A/B  out  BP_SEL_W; oIF_BP_Select_Imm  out  1.

Function
REQ-019 Registers rFetch_PC, rResp_PC, rResp_Valid track the in-flight IMEM read.
REQ-020 oIF_IMEM_Addr: iStall=1 -> rResp_PC; else branch taken -> target; else rFetch_PC.
REQ-021 Not stalled: rResp_PC <= oIF_IMEM_Addr, rFetch_PC <= oIF_IMEM_Addr+1 (mod 2^PC_W, wraps), rResp_Valid <= 1.
REQ-022 Stalled: rFetch_PC, rResp_PC, rResp_Valid and all ID-side outputs hold; branch flag ignored (stall wins).
REQ-023 Not stalled: ID registers capture iIMEM_IF_Instruction, rResp_PC, sideband; oIF_ID_Valid <= rResp_Valid.
REQ-024 Branch taken with DELAY_SLOT=0 and not stalled: captured slot has Valid=0, Instruction=0, Branch_Op=BRANCHOP_NOP, Select_Imm=0, bypass flags 0.
REQ-025 Branch taken with DELAY_SLOT=1: in-flight instruction captured normally.
REQ-026 Latency: address driven in cycle t appears on ID outputs after edge t+2 absent stall.
REQ-027 Bypass A/B flag = upper index bits all ones; captured each unstalled cycle.
REQ-028 Read_Addr_A/B load source field only when not bypassed; otherwise hold.
REQ-029 Bypass_Sel_A/B load low BP_SEL_W field bits only when bypassed; otherwise hold.
REQ-030 Select_Imm <= 1 when instruction[TYPE_BIT]=1 (I-type), else 0.
REQ-031 Branch_Op <= instruction[INS_W-6:INS_W-8] when instruction[INS_W-1:INS_W-5]=0, else BRANCHOP_NOP.
REQ-032 Stall released: IMEM output equals instruction at rResp_PC, so no instruction lost or duplicated.

Reset
REQ-033 iReset_n=0 asynchronously: rFetch_PC=BOOT_PC, rResp_PC=BOOT_PC, rResp_Valid=0, oIF_ID_Valid=0, all other outputs 0, Branch_Op=BRANCHOP_NOP.
REQ-034 During reset oIF_IMEM_Addr=BOOT_PC; reset asserted mid-stall or mid-branch discards all state.
REQ-035 First edge after deassertion: rResp_Valid=1; next edge: oIF_ID_Valid=1, oIF_ID_PC=BOOT_PC.

Verification
REQ-036 Reset release, IMEM[k]=k+0x100 -> ID PC sequence 0,1,2..., Instruction 0x100,0x101..., Valid from 2nd edge.
REQ-037 Stall 3 cycles while ID holds PC 5 -> outputs held; after release PC 6,7 follow, no gap or repeat.
REQ-038 Branch to 0x40 at fetch of PC 8, DELAY_SLOT=1 -> ID sees 8,9,0x40; DELAY_SLOT=0 -> 8, bubble (Valid=0), 0x40.
REQ-039 Stall and branch same cycle -> branch ignored, PC held; branch reasserted post-stall redirects.
REQ-040 SRC1=5'b11110, SRC2=5'b00011 -> Bypass_Read_A=1, Sel_A=2'b10, Read_Addr_A held; Read_Addr_B=3.
REQ-041 PC=2^PC_W-1 -> next fetch 0; async reset mid-stream -> all outputs reset same cycle.

Source files
------------

// File: rtl/cp_if_pipe_if.sv
// Fetch-stage bus bundle for cp_if_pipe.
//   master : the fetch stage (drives IMEM address and the IF/ID register outputs)
//   slave  : the surrounding core (ID stall/redirect, IMEM read data, PE sideband)
interface cp_if_pipe_if #(
  parameter int unsigned PC_W     = 10,
  parameter int unsigned INS_W    = 24,
  parameter int unsigned RF_IDX_W = 5,
  parameter int unsigned BP_SEL_W = 2,
  parameter int unsigned PRED_W   = 2
);
  logic                iStall;
  logic                iID_IF_Branch_Taken_Flag;
  logic [PC_W-1:0]     iID_IF_Branch_Target_Addr;
  logic [INS_W-1:0]    iIMEM_IF_Instruction;
  logic                iSelect_First_PE;
  logic                iSelect_Last_PE;
  logic [PRED_W-1:0]   iPredication;

  logic [PC_W-1:0]     oIF_IMEM_Addr;
  logic                oIF_ID_Valid;
  logic [PC_W-1:0]     oIF_ID_PC;
  logic [INS_W-1:0]    oIF_ID_Instruction;
  logic [2:0]          oIF_ID_Branch_Op;
  logic                oSelect_First_PE;
  logic                oSelect_Last_PE;
  logic [PRED_W-1:0]   oPredication;
  logic [RF_IDX_W-1:0] oIF_RF_Read_Addr_A;
  logic [RF_IDX_W-1:0] oIF_RF_Read_Addr_B;
  logic                oIF_BP_Bypass_Read_A;
  logic                oIF_BP_Bypass_Read_B;
  logic [BP_SEL_W-1:0] oIF_BP_Bypass_Sel_A;
  logic [BP_SEL_W-1:0] oIF_BP_Bypass_Sel_B;
  logic                oIF_BP_Select_Imm;

  modport master (
    input  iStall, iID_IF_Branch_Taken_Flag, iID_IF_Branch_Target_Addr,
           iIMEM_IF_Instruction, iSelect_First_PE, iSelect_Last_PE, iPredication,
    output oIF_IMEM_Addr, oIF_ID_Valid, oIF_ID_PC, oIF_ID_Instruction, oIF_ID_Branch_Op,
           oSelect_First_PE, oSelect_Last_PE, oPredication,
           oIF_RF_Read_Addr_A, oIF_RF_Read_Addr_B, oIF_BP_Bypass_Read_A, oIF_BP_Bypass_Read_B,
           oIF_BP_Bypass_Sel_A, oIF_BP_Bypass_Sel_B, oIF_BP_Select_Imm
  );

  modport slave (
    output iStall, iID_IF_Branch_Taken_Flag, iID_IF_Branch_Target_Addr,
           iIMEM_IF_Instruction, iSelect_First_PE, iSelect_Last_PE, iPredication,
    input  oIF_IMEM_Addr, oIF_ID_Valid, oIF_ID_PC, oIF_ID_Instruction, oIF_ID_Branch_Op,
           oSelect_First_PE, oSelect_Last_PE, oPredication,
           oIF_RF_Read_Addr_A, oIF_RF_Read_Addr_B, oIF_BP_Bypass_Read_A, oIF_BP_Bypass_Read_B,
           oIF_BP_Bypass_Sel_A, oIF_BP_Bypass_Sel_B, oIF_BP_Select_Imm
  );
endinterface

// File: rtl/cp_if_pipe.sv
// Instruction fetch stage with an IF/ID pipeline register.
// Ports:
//   iClk, iReset_n : clock (rising edge), asynchronous active-low reset
//   bus (master)   : IMEM address out / read data in (one-cycle latency),
//                    ID stall and branch redirect in, PE sideband in,
//                    registered IF/ID outputs (valid, PC, instruction, branch op,
//                    sideband, RF read indices, bypass flags/selects, immediate select)
module cp_if_pipe #(
  parameter int unsigned   PC_W         = 10,
  parameter int unsigned   INS_W        = 24,
  parameter int unsigned   RF_IDX_W     = 5,
  parameter int unsigned   BP_SEL_W     = 2,
  parameter int unsigned   SRC1_LSB     = 12,
  parameter int unsigned   SRC2_LSB     = 7,
  parameter int unsigned   TYPE_BIT     = 18,
  parameter int unsigned   PRED_W       = 2,
  parameter logic [PC_W-1:0] BOOT_PC    = '0,
  parameter logic          DELAY_SLOT   = 1'b1,
  parameter logic [2:0]    BRANCHOP_NOP = 3'd0
) (
  input  logic iClk,
  input  logic iReset_n,
  cp_if_pipe_if.master bus
);

  localparam int unsigned TAG_W   = RF_IDX_W - BP_SEL_W;
  localparam int unsigned OPC_HI  = INS_W - 1;
  localparam int unsigned BOP_HI  = INS_W - 6;

  logic [PC_W-1:0]     fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]     resp_pc_q, resp_pc_d;
  logic                resp_valid_q, resp_valid_d;

  logic                id_valid_q, id_valid_d;
  logic [PC_W-1:0]     id_pc_q, id_pc_d;
  logic [INS_W-1:0]    id_ins_q, id_ins_d;
  logic [2:0]          id_bop_q, id_bop_d;
  logic                id_first_q, id_first_d;
  logic                id_last_q, id_last_d;
  logic [PRED_W-1:0]   id_pred_q, id_pred_d;
  logic [RF_IDX_W-1:0] rd_addr_a_q, rd_addr_a_d;
  logic [RF_IDX_W-1:0] rd_addr_b_q, rd_addr_b_d;
  logic                bp_rd_a_q, bp_rd_a_d;
  logic                bp_rd_b_q, bp_rd_b_d;
  logic [BP_SEL_W-1:0] bp_sel_a_q, bp_sel_a_d;
  logic [BP_SEL_W-1:0] bp_sel_b_q, bp_sel_b_d;
  logic                sel_imm_q, sel_imm_d;

  logic [PC_W-1:0]     imem_addr;
  logic                squash;
  logic [INS_W-1:0]    slot_ins;
  logic [RF_IDX_W-1:0] src_a, src_b;
  logic                bypass_a, bypass_b;

  // IMEM address: a stall re-reads the held slot so its data is current on release
  always_comb begin
    imem_addr = fetch_pc_q;
    if (!iReset_n)
      imem_addr = BOOT_PC;
    else if (bus.iStall)
      imem_addr = resp_pc_q;
    else if (bus.iID_IF_Branch_Taken_Flag)
      imem_addr = bus.iID_IF_Branch_Target_Addr;
  end

  // Slot decode; a squashed delay slot is decoded as an all-zero instruction
  always_comb begin
    squash   = bus.iID_IF_Branch_Taken_Flag && (DELAY_SLOT == 1'b0);
    slot_ins = squash ? '0 : bus.iIMEM_IF_Instruction;
    src_a    = slot_ins[SRC1_LSB +: RF_IDX_W];
    src_b    = slot_ins[SRC2_LSB +: RF_IDX_W];
    bypass_a = &src_a[RF_IDX_W-1 -: TAG_W];
    bypass_b = &src_b[RF_IDX_W-1 -: TAG_W];
  end

  // Next-state for fetch tracking and the IF/ID register; everything holds on stall
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    resp_pc_d    = resp_pc_q;
    resp_valid_d = resp_valid_q;
    id_valid_d   = id_valid_q;
    id_pc_d      = id_pc_q;
    id_ins_d     = id_ins_q;
    id_bop_d     = id_bop_q;
    id_first_d   = id_first_q;
    id_last_d    = id_last_q;
    id_pred_d    = id_pred_q;
    rd_addr_a_d  = rd_addr_a_q;
    rd_addr_b_d  = rd_addr_b_q;
    bp_rd_a_d    = bp_rd_a_q;
    bp_rd_b_d    = bp_rd_b_q;
    bp_sel_a_d   = bp_sel_a_q;
    bp_sel_b_d   = bp_sel_b_q;
    sel_imm_d    = sel_imm_q;

    if (!bus.iStall) begin
      resp_pc_d    = imem_addr;
      fetch_pc_d   = imem_addr + PC_W'(1);
      resp_valid_d = 1'b1;

      id_valid_d   = resp_valid_q && !squash;
      id_pc_d      = resp_pc_q;
      id_ins_d     = slot_ins;
      id_first_d   = bus.iSelect_First_PE;
      id_last_d    = bus.iSelect_Last_PE;
      id_pred_d    = bus.iPredication;
      sel_imm_d    = slot_ins[TYPE_BIT];

      if (squash || (slot_ins[OPC_HI -: 5] != 5'd0))
        id_bop_d = BRANCHOP_NOP;
      else
        id_bop_d = slot_ins[BOP_HI -: 3];

      // Read index and bypass select are mutually exclusive loads
      bp_rd_a_d = bypass_a;
      bp_rd_b_d = bypass_b;
      if (bypass_a) bp_sel_a_d = src_a[BP_SEL_W-1:0];
      else          rd_addr_a_d = src_a;
      if (bypass_b) bp_sel_b_d = src_b[BP_SEL_W-1:0];
      else          rd_addr_b_d = src_b;
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      fetch_pc_q   <= BOOT_PC;
      resp_pc_q    <= BOOT_PC;
      resp_valid_q <= 1'b0;
      id_valid_q   <= 1'b0;
      id_pc_q      <= '0;
      id_ins_q     <= '0;
      id_bop_q     <= BRANCHOP_NOP;
      id_first_q   <= 1'b0;
      id_last_q    <= 1'b0;
      id_pred_q    <= '0;
      rd_addr_a_q  <= '0;
      rd_addr_b_q  <= '0;
      bp_rd_a_q    <= 1'b0;
      bp_rd_b_q    <= 1'b0;
      bp_sel_a_q   <= '0;
      bp_sel_b_q   <= '0;
      sel_imm_q    <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      resp_pc_q    <= resp_pc_d;
      resp_valid_q <= resp_valid_d;
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_ins_q     <= id_ins_d;
      id_bop_q     <= id_bop_d;
      id_first_q   <= id_first_d;
      id_last_q    <= id_last_d;
      id_pred_q    <= id_pred_d;
      rd_addr_a_q  <= rd_addr_a_d;
      rd_addr_b_q  <= rd_addr_b_d;
      bp_rd_a_q    <= bp_rd_a_d;
      bp_rd_b_q    <= bp_rd_b_d;
      bp_sel_a_q   <= bp_sel_a_d;
      bp_sel_b_q   <= bp_sel_b_d;
      sel_imm_q    <= sel_imm_d;
    end
  end

  assign bus.oIF_IMEM_Addr        = imem_addr;
  assign bus.oIF_ID_Valid         = id_valid_q;
  assign bus.oIF_ID_PC            = id_pc_q;
  assign bus.oIF_ID_Instruction   = id_ins_q;
  assign bus.oIF_ID_Branch_Op     = id_bop_q;
  assign bus.oSelect_First_PE     = id_first_q;
  assign bus.oSelect_Last_PE      = id_last_q;
  assign bus.oPredication         = id_pred_q;
  assign bus.oIF_RF_Read_Addr_A   = rd_addr_a_q;
  assign bus.oIF_RF_Read_Addr_B   = rd_addr_b_q;
  assign bus.oIF_BP_Bypass_Read_A = bp_rd_a_q;
  assign bus.oIF_BP_Bypass_Read_B = bp_rd_b_q;
  assign bus.oIF_BP_Bypass_Sel_A  = bp_sel_a_q;
  assign bus.oIF_BP_Bypass_Sel_B  = bp_sel_b_q;
  assign bus.oIF_BP_Select_Imm    = sel_imm_q;

endmodule

// File: tb/tb_cp_if_pipe.sv
// Bench for cp_if_pipe: two instances (delay slot kept / squashed) share all stimulus.
module tb_cp_if_pipe;
  localparam int unsigned PC_W  = 10;
  localparam int unsigned INS_W = 24;
  localparam int unsigned DEPTH = 1 << PC_W;
  localparam logic [PC_W-1:0] BOOT = 10'd0;

  typedef struct packed {
    logic             v;
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] ins;
    logic [2:0]       bop;
    logic             f;
    logic             l;
    logic [1:0]       pred;
    logic [4:0]       ra;
    logic [4:0]       rb;
    logic             bpa;
    logic             bpb;
    logic [1:0]       sa;
    logic [1:0]       sb;
    logic             imm;
  } id_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0, taken = 1'b0, sf = 1'b0, sl = 1'b0;
  logic [PC_W-1:0] target = '0;
  logic [1:0] pred = '0;
  logic [INS_W-1:0] mem [DEPTH];
  logic [INS_W-1:0] rd_a, rd_b;

  always #5 clk = ~clk;

  cp_if_pipe_if bus_a ();
  cp_if_pipe_if bus_b ();

  cp_if_pipe #(.DELAY_SLOT(1'b1)) dut_ds1 (.iClk(clk), .iReset_n(rst_n), .bus(bus_a));
  cp_if_pipe #(.DELAY_SLOT(1'b0)) dut_ds0 (.iClk(clk), .iReset_n(rst_n), .bus(bus_b));

  assign bus_a.iStall = stall;                     assign bus_b.iStall = stall;
  assign bus_a.iID_IF_Branch_Taken_Flag = taken;   assign bus_b.iID_IF_Branch_Taken_Flag = taken;
  assign bus_a.iID_IF_Branch_Target_Addr = target; assign bus_b.iID_IF_Branch_Target_Addr = target;
  assign bus_a.iSelect_First_PE = sf;              assign bus_b.iSelect_First_PE = sf;
  assign bus_a.iSelect_Last_PE = sl;               assign bus_b.iSelect_Last_PE = sl;
  assign bus_a.iPredication = pred;                assign bus_b.iPredication = pred;
  assign bus_a.iIMEM_IF_Instruction = rd_a;        assign bus_b.iIMEM_IF_Instruction = rd_b;

  // Synchronous IMEM, one per instance
  always @(posedge clk) begin
    rd_a <= mem[bus_a.oIF_IMEM_Addr];
    rd_b <= mem[bus_b.oIF_IMEM_Addr];
  end

  id_t act0, act1;
  assign act0 = {bus_a.oIF_ID_Valid, bus_a.oIF_ID_PC, bus_a.oIF_ID_Instruction, bus_a.oIF_ID_Branch_Op,
                 bus_a.oSelect_First_PE, bus_a.oSelect_Last_PE, bus_a.oPredication,
                 bus_a.oIF_RF_Read_Addr_A, bus_a.oIF_RF_Read_Addr_B, bus_a.oIF_BP_Bypass_Read_A,
                 bus_a.oIF_BP_Bypass_Read_B, bus_a.oIF_BP_Bypass_Sel_A, bus_a.oIF_BP_Bypass_Sel_B,
                 bus_a.oIF_BP_Select_Imm};
  assign act1 = {bus_b.oIF_ID_Valid, bus_b.oIF_ID_PC, bus_b.oIF_ID_Instruction, bus_b.oIF_ID_Branch_Op,
                 bus_b.oSelect_First_PE, bus_b.oSelect_Last_PE, bus_b.oPredication,
                 bus_b.oIF_RF_Read_Addr_A, bus_b.oIF_RF_Read_Addr_B, bus_b.oIF_BP_Bypass_Read_A,
                 bus_b.oIF_BP_Bypass_Read_B, bus_b.oIF_BP_Bypass_Sel_A, bus_b.oIF_BP_Bypass_Sel_B,
                 bus_b.oIF_BP_Select_Imm};

  int total = 0;
  int bad = 0;
  id_t q0[$];
  id_t q1[$];

  // Reference state: address whose data is in flight, next sequential address, expected ID view
  logic [PC_W-1:0] m_inpc = BOOT;
  logic [PC_W-1:0] m_nxt = BOOT;
  bit m_inv = 1'b0;
  id_t m_id [2];

  task automatic cmp(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  // What the ID stage should show after capturing one slot
  function automatic id_t capture(id_t prev, bit in_valid, bit squashed, logic [PC_W-1:0] pc,
                                  logic [INS_W-1:0] ins, logic f, logic l, logic [1:0] pr);
    id_t n = prev;
    int w = squashed ? 0 : int'(ins);
    int s1 = (w / 4096) % 32;
    int s2 = (w / 128) % 32;
    n.v    = in_valid && !squashed;
    n.pc   = pc;
    n.ins  = INS_W'(w);
    n.f    = f;
    n.l    = l;
    n.pred = pr;
    n.imm  = ((w / (1 << 18)) % 2) == 1;
    n.bop  = ((w / (1 << 19)) == 0) ? 3'((w / (1 << 16)) % 8) : 3'd0;
    n.bpa  = (s1 / 4) == 7;
    n.bpb  = (s2 / 4) == 7;
    if (n.bpa) n.sa = 2'(s1 % 4); else n.ra = 5'(s1);
    if (n.bpb) n.sb = 2'(s2 % 4); else n.rb = 5'(s2);
    return n;
  endfunction

  task automatic cyc(input bit r, input bit s, input bit t, input logic [PC_W-1:0] tg);
    logic [PC_W-1:0] exp_addr;
    logic prev_rst;
    @(negedge clk);
    prev_rst = rst_n;
    rst_n = r; stall = s; taken = t; target = tg;
    sf = 1'($urandom); sl = 1'($urandom); pred = 2'($urandom);
    #1;
    if (!r) exp_addr = BOOT;
    else if (s) exp_addr = m_inpc;
    else if (t) exp_addr = tg;
    else exp_addr = m_nxt;
    cmp("imem_addr_ds1", 64'(bus_a.oIF_IMEM_Addr), 64'(exp_addr));
    cmp("imem_addr_ds0", 64'(bus_b.oIF_IMEM_Addr), 64'(exp_addr));
    if (!r && prev_rst) begin
      cmp("async_reset_ds1", 64'(act0), 64'(0));
      cmp("async_reset_ds0", 64'(act1), 64'(0));
    end
    if (!r) begin
      m_inpc = BOOT; m_nxt = BOOT; m_inv = 1'b0;
      m_id[0] = '0; m_id[1] = '0;
    end else if (!s) begin
      m_id[0] = capture(m_id[0], m_inv, 1'b0, m_inpc, mem[m_inpc], sf, sl, pred);
      m_id[1] = capture(m_id[1], m_inv, t,    m_inpc, mem[m_inpc], sf, sl, pred);
      m_inpc = exp_addr;
      m_nxt  = exp_addr + 10'd1;
      m_inv  = 1'b1;
    end
    q0.push_back(m_id[0]);
    q1.push_back(m_id[1]);
  endtask

  // Monitor: one expected ID view per clock edge for each instance
  initial begin
    id_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin e = q0.pop_front(); cmp("id_ds1", 64'(act0), 64'(e)); end
      if (q1.size() > 0) begin e = q1.pop_front(); cmp("id_ds0", 64'(act1), 64'(e)); end
    end
  end

  initial begin
    m_id[0] = '0; m_id[1] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = INS_W'($urandom);
      if (i % 5 == 0) mem[i] = mem[i] & 24'h07FFFF;   // branch-op opcode space
    end
    for (int k = 0; k < 32; k++) mem[k] = INS_W'(k + 'h100);
    mem[20] = INS_W'((30 << 12) | (3 << 7));          // src1 bypassed, src2 = r3

    repeat (3) cyc(1'b0, 1'b0, 1'b0, '0);
    repeat (10) cyc(1'b1, 1'b0, 1'b0, '0);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, '0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b1, 10'h040);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b1, 1'b1, 10'h080);                   // stall wins over redirect
    cyc(1'b1, 1'b0, 1'b1, 10'h080);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, '0);
    repeat (12) cyc(1'b1, 1'b0, 1'b0, '0);            // walks through the bypass word
    cyc(1'b1, 1'b0, 1'b1, 10'h3FE);
    repeat (4) cyc(1'b1, 1'b0, 1'b0, '0);             // wraps past 0x3FF

    repeat (400) cyc(1'b1, ($urandom % 4) == 0, ($urandom % 8) == 0,
                     (($urandom % 4) == 0) ? 10'h3FF : PC_W'($urandom));
    cyc(1'b1, 1'b1, 1'b1, 10'h123);
    cyc(1'b0, 1'b1, 1'b1, 10'h123);                   // reset mid-stall, mid-branch
    cyc(1'b0, 1'b0, 1'b1, 10'h123);
    repeat (200) cyc(1'b1, ($urandom % 4) == 0, ($urandom % 8) == 0, PC_W'($urandom));

    repeat (2) @(negedge clk);
    cmp("scoreboard_drained", 64'(q0.size() + q1.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
